// File: rtl/imem_loader.sv
// Serial program loader for the CPU's instruction memory. It receives a framed byte stream
// (count, low/high byte pairs, XOR checksum) and holds the CPU in reset until a good load completes.
module imem_loader #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        LO,
        HI,
        WRITE,
        CHECK,
        DONE,
        ERR
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [7:0]          r_count;
    logic [ADDR_W-1:0]   r_idx;
    logic [7:0]          r_chk;
    logic [7:0]          r_lo;
    logic [ADDR_W-1:0]   r_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic                r_we;
    logic                r_ready;
    logic                r_hold;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                w_accept;
    logic                w_lastWord;
    logic                w_hiOk;

    assign w_accept   = byte_valid && r_ready;
    assign w_lastWord = (r_idx == ADDR_W'(r_count));
    assign w_hiOk     = (byte_in[7:4] == 4'h0);

    // Next-state decode; start is honoured only from the resting states.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (start) w_nextState = COUNT;
            COUNT:           if (w_accept) w_nextState = LO;
            LO:              if (w_accept) w_nextState = HI;
            HI:              if (w_accept) w_nextState = w_hiOk ? WRITE : ERR;
            WRITE:           w_nextState = w_lastWord ? CHECK : LO;
            CHECK:           if (w_accept) w_nextState = (byte_in == r_chk) ? DONE : ERR;
            default:         w_nextState = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 8'h00;
            r_idx   <= '0;
            r_chk   <= 8'h00;
            r_lo    <= 8'h00;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_ready <= 1'b0;
            r_hold  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState == COUNT) || (w_nextState == LO) ||
                       (w_nextState == HI)    || (w_nextState == CHECK);
            r_we    <= (w_nextState == WRITE);
            r_hold  <= (w_nextState != DONE);
            r_busy  <= (w_nextState == COUNT) || (w_nextState == LO) ||
                       (w_nextState == HI)    || (w_nextState == WRITE) ||
                       (w_nextState == CHECK);
            r_done  <= (w_nextState == DONE);
            r_err   <= (w_nextState == ERR);

            case (r_state)
                COUNT: begin
                    if (w_accept) begin
                        r_count <= byte_in;
                        r_idx   <= '0;
                        r_chk   <= byte_in;
                    end
                end
                LO: begin
                    if (w_accept) begin
                        r_lo  <= byte_in;
                        r_chk <= r_chk ^ byte_in;
                    end
                end
                HI: begin
                    // Address and data are captured here so they are valid during the WRITE cycle.
                    if (w_accept) begin
                        r_chk <= r_chk ^ byte_in;
                        if (w_hiOk) begin
                            r_addr  <= r_idx;
                            r_wdata <= WIDTH'({byte_in[3:0], r_lo});
                        end
                    end
                end
                WRITE: begin
                    if (!w_lastWord) r_idx <= r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: drives framed byte streams and checks the memory writes
// and status outputs against hand-computed values.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [11:0] imem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    int errors = 0;
    int checks = 0;
    int readyDuringWrite = 0;
    logic [7:0]  wrAddr[$];
    logic [11:0] wrData[$];

    imem_loader #(.WIDTH(12), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen mid-cycle, and flag any cycle that is writing while ready.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wrAddr.push_back(imem_addr);
            wrData.push_back(imem_wdata);
            if (byte_ready !== 1'b0) readyDuringWrite++;
        end
    end

    task automatic doStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap, input logic withStart);
        int t;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        start      = withStart;
        t = 0;
        while (byte_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL byte_timeout: got ready=%b required ready=1 for byte %h", byte_ready, b);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({byte_ready, imem_we, cpu_hold, busy, done, error} !== 6'b001000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b required 001000",
                     {byte_ready, imem_we, cpu_hold, busy, done, error});
        end
        checks++;
        if (imem_addr !== 8'h00 || imem_wdata !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_bus: got addr=%h data=%h required 00/000", imem_addr, imem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_hold !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_flags: got hold=%b ready=%b busy=%b required 1/0/0",
                     cpu_hold, byte_ready, busy);
        end
    endtask

    task automatic test_basic_load();
        wrAddr.delete();
        wrData.delete();
        doStart();
        checks++;
        if (busy !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || byte_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_started: got busy=%b hold=%b done=%b ready=%b required 1/1/0/1",
                     busy, cpu_hold, done, byte_ready);
        end
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'h34, 0, 1'b0);
        sendByte(8'h02, 0, 1'b0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h00 || imem_wdata !== 12'h234) begin
            errors++;
            $display("[TB] FAIL basic_write_latency: got we=%b addr=%h data=%h required 1/00/234",
                     imem_we, imem_addr, imem_wdata);
        end
        sendByte(8'h78, 0, 1'b0);
        sendByte(8'h0A, 0, 1'b0);
        sendByte(8'h45, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_done: got done=%b err=%b hold=%b busy=%b required 1/0/0/0",
                     done, error, cpu_hold, busy);
        end
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL basic_write_count: got %0d required 2", wrAddr.size());
        end else if (wrAddr[0] !== 8'h00 || wrData[0] !== 12'h234 ||
                     wrAddr[1] !== 8'h01 || wrData[1] !== 12'hA78) begin
            errors++;
            $display("[TB] FAIL basic_writes: got %h=%h %h=%h required 00=234 01=a78",
                     wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
        end
    endtask

    task automatic test_single_word();
        wrAddr.delete();
        wrData.delete();
        doStart();
        checks++;
        if (cpu_hold !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reload_hold: got hold=%b done=%b required 1/0", cpu_hold, done);
        end
        sendByte(8'h00, 0, 1'b0);
        sendByte(8'hFF, 0, 1'b0);
        sendByte(8'h0F, 0, 1'b0);
        sendByte(8'hF0, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_done: got done=%b err=%b hold=%b required 1/0/0",
                     done, error, cpu_hold);
        end
        checks++;
        if (wrAddr.size() != 1) begin
            errors++;
            $display("[TB] FAIL single_write_count: got %0d required 1", wrAddr.size());
        end else if (wrAddr[0] !== 8'h00 || wrData[0] !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL single_write: got %h=%h required 00=fff", wrAddr[0], wrData[0]);
        end
    endtask

    task automatic test_bad_checksum();
        wrAddr.delete();
        wrData.delete();
        doStart();
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'h34, 0, 1'b0);
        sendByte(8'h02, 0, 1'b0);
        sendByte(8'h78, 0, 1'b0);
        sendByte(8'h0A, 0, 1'b0);
        sendByte(8'h44, 0, 1'b0);
        checks++;
        if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL badchk_status: got err=%b done=%b hold=%b busy=%b required 1/0/1/0",
                     error, done, cpu_hold, busy);
        end
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL badchk_write_count: got %0d required 2", wrAddr.size());
        end else if (wrData[0] !== 12'h234 || wrData[1] !== 12'hA78) begin
            errors++;
            $display("[TB] FAIL badchk_writes: got %h %h required 234 a78", wrData[0], wrData[1]);
        end
    endtask

    task automatic test_format_error();
        wrAddr.delete();
        wrData.delete();
        doStart();
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fmt_error_cleared: got err=%b busy=%b required 0/1", error, busy);
        end
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'h34, 0, 1'b0);
        sendByte(8'h1A, 0, 1'b0);
        checks++;
        if (error !== 1'b1 || byte_ready !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fmt_status: got err=%b ready=%b we=%b done=%b required 1/0/0/0",
                     error, byte_ready, imem_we, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (wrAddr.size() != 0 || error !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fmt_no_write: got writes=%0d err=%b required 0/1", wrAddr.size(), error);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream [6];
        stream = '{8'h01, 8'h34, 8'h02, 8'h78, 8'h0A, 8'h45};
        wrAddr.delete();
        wrData.delete();
        readyDuringWrite = 0;
        doStart();
        for (int i = 0; i < 6; i++) begin
            sendByte(stream[i], int'($urandom_range(0, 3)), (i == 2 || i == 4));
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_done: got done=%b err=%b hold=%b required 1/0/0", done, error, cpu_hold);
        end
        checks++;
        if (wrAddr.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b_write_count: got %0d required 2", wrAddr.size());
        end else if (wrAddr[0] !== 8'h00 || wrData[0] !== 12'h234 ||
                     wrAddr[1] !== 8'h01 || wrData[1] !== 12'hA78) begin
            errors++;
            $display("[TB] FAIL b2b_writes: got %h=%h %h=%h required 00=234 01=a78",
                     wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
        end
        checks++;
        if (readyDuringWrite != 0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_in_write: got %0d cycles required 0", readyDuringWrite);
        end
    endtask

    task automatic test_reset_mid_load();
        wrAddr.delete();
        wrData.delete();
        doStart();
        sendByte(8'hFF, 0, 1'b0);
        sendByte(8'h11, 0, 1'b0);
        sendByte(8'h01, 0, 1'b0);
        sendByte(8'h22, 0, 1'b0);
        sendByte(8'h02, 0, 1'b0);
        checks++;
        if (imem_we !== 1'b1 || imem_addr !== 8'h01 || imem_wdata !== 12'h222) begin
            errors++;
            $display("[TB] FAIL midload_write1: got we=%b addr=%h data=%h required 1/01/222",
                     imem_we, imem_addr, imem_wdata);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({byte_ready, imem_we, cpu_hold, busy, done, error} !== 6'b001000) begin
            errors++;
            $display("[TB] FAIL midload_reset_flags: got %b required 001000",
                     {byte_ready, imem_we, cpu_hold, busy, done, error});
        end
        checks++;
        if (imem_addr !== 8'h00 || imem_wdata !== 12'h000) begin
            errors++;
            $display("[TB] FAIL midload_reset_bus: got addr=%h data=%h required 00/000", imem_addr, imem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        wrAddr.delete();
        wrData.delete();
        doStart();
        sendByte(8'h00, 0, 1'b0);
        sendByte(8'hFF, 0, 1'b0);
        sendByte(8'h0F, 0, 1'b0);
        sendByte(8'hF0, 0, 1'b0);
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || wrAddr.size() != 1) begin
            errors++;
            $display("[TB] FAIL fresh_load: got done=%b err=%b writes=%0d required 1/0/1",
                     done, error, wrAddr.size());
        end else if (wrData[0] !== 12'hFFF) begin
            errors++;
            $display("[TB] FAIL fresh_load_data: got %h required fff", wrData[0]);
        end
    endtask

    initial begin
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        test_reset();
        test_basic_load();
        test_single_word();
        test_bad_checksum();
        test_format_error();
        test_back_to_back();
        test_reset_mid_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
